// File: rtl/sync_nbank_fifo_pkg.sv
// Shared constants and width helpers for the banked synchronous FIFO.
//   PREFETCH_DEPTH : entries in the register FIFO that feeds out_data
//   RAM_RD_LATENCY : cycles from read issue to data landing in the prefetch FIFO
//   bank_idx_width : bits needed to select a bank
//   bank_addr_width: address bits inside one bank
package sync_nbank_fifo_pkg;

    localparam int PREFETCH_DEPTH = 4;
    localparam int RAM_RD_LATENCY = 2;

    function automatic int bank_idx_width(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    function automatic int bank_addr_width(input int fifo_depth, input int num_banks);
        return (fifo_depth / num_banks > 1) ? $clog2(fifo_depth / num_banks) : 1;
    endfunction

endpackage

// File: rtl/reg_fifo.sv
// Small flop-based FIFO with show-ahead output.
//   clk, rstn : clock, asynchronous active-low reset
//   clear     : synchronous flush (wins over push/pop)
//   push      : write push_data (ignored when full)
//   pop       : drop the head entry (ignored when empty)
//   pop_data  : head entry
//   valid     : at least one entry held
//   cnt       : entries held
module reg_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    pop_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_push  = push && (cnt != CW'(DEPTH));
    assign do_pop   = pop && (cnt != '0);
    assign pop_data = mem[rptr];
    assign valid    = (cnt != '0);

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= ptr_next(wptr);
            end
            if (do_pop) begin
                rptr <= ptr_next(rptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/single_port_RAM.sv
// Single-port RAM, one access per cycle, registered read data.
//   clk   : clock
//   en    : access enable
//   we    : write (1) or read (0) when en is high
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after a read access
// Contents are not reset.
module single_port_RAM #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 128
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sync_nbank_fifo.sv
// Synchronous FIFO built from NUM_BANKS interleaved single-port RAMs with a
// small prefetch register FIFO in front of the read port. Word n lives in
// bank (n mod NUM_BANKS) at row (n / NUM_BANKS), so consecutive writes and
// prefetch reads normally hit different banks and proceed in the same cycle.
//   clk, rstn            : clock, asynchronous active-low reset
//   in_data/valid/ready  : write handshake
//   out_data/valid/ready : read handshake (data from the prefetch FIFO head)
//   clear                : synchronous flush, discards a concurrent write
//   count                : words held (RAM + in-flight + prefetch)
//   almost_full/empty    : only with SYNC_NBANK_FIFO_ALMOST_FLAGS_EN defined
module sync_nbank_fifo
    import sync_nbank_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 256,
    parameter int NUM_BANKS  = 2,
    parameter int AF_MARGIN  = 4,
    parameter int AE_MARGIN  = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          clear,
    output logic [$clog2(FIFO_DEPTH):0]   count
`ifdef SYNC_NBANK_FIFO_ALMOST_FLAGS_EN
    ,
    output logic                          almost_full,
    output logic                          almost_empty
`endif
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BIW = bank_idx_width(NUM_BANKS);
    localparam int BAW = bank_addr_width(FIFO_DEPTH, NUM_BANKS);
    localparam int PCW = $clog2(PREFETCH_DEPTH) + 1;

    if (NUM_BANKS < 2 || (NUM_BANKS & (NUM_BANKS - 1)) != 0 ||
        (FIFO_DEPTH % NUM_BANKS) != 0 || AW != BIW + BAW ||
        AF_MARGIN > FIFO_DEPTH || AE_MARGIN > FIFO_DEPTH ||
        RAM_RD_LATENCY != 2) begin : g_bad_cfg
        $error("sync_nbank_fifo: unsupported parameter set");
    end

    logic [AW-1:0]         waddr;
    logic [AW-1:0]         raddr;
    logic                  rd_vld;
    logic [BIW-1:0]        rd_bank;
    logic [PCW-1:0]        pf_cnt;
    logic [PCW-1:0]        pf_load;
    logic [DATA_WIDTH-1:0] ram_q [NUM_BANKS];
    logic [CW-1:0]         unread;
    logic [BIW-1:0]        wbank;
    logic [BIW-1:0]        rbank;
    logic [BAW-1:0]        wrow;
    logic [BAW-1:0]        rrow;
    logic                  want_read;
    logic                  same_bank;
    logic                  read_priority_conflict;
    logic                  wr_fire;
    logic                  rd_issue;
    logic                  out_fire;

    assign wbank = waddr[BIW-1:0];
    assign rbank = raddr[BIW-1:0];
    assign wrow  = waddr[AW-1:BIW];
    assign rrow  = raddr[AW-1:BIW];

    function automatic logic [AW-1:0] addr_next(input logic [AW-1:0] a);
        return (a == AW'(FIFO_DEPTH - 1)) ? '0 : a + AW'(1);
    endfunction

    // Everything downstream of the RAMs (in-flight + prefetch) is what a new
    // read would have to queue behind; it also bounds prefetch FIFO fill.
    always_comb begin
        pf_load   = pf_cnt + PCW'(rd_vld);
        unread    = count - CW'(pf_cnt) - CW'(rd_vld);
        want_read = (unread != '0) && (pf_load < PCW'(PREFETCH_DEPTH));
        same_bank = (wbank == rbank);
        // When the output side is about to run dry a same-bank read beats
        // the write, otherwise the stream could starve.
        read_priority_conflict = want_read && same_bank && (pf_load <= PCW'(1));
        in_ready  = rstn && (count < CW'(FIFO_DEPTH)) && !read_priority_conflict;
        wr_fire   = in_valid && in_ready && !clear;
        rd_issue  = want_read && !clear && !(wr_fire && same_bank);
        out_fire  = out_valid && out_ready && !clear;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic bank_wr;
        logic bank_rd;

        assign bank_wr = wr_fire && (wbank == BIW'(b));
        assign bank_rd = rd_issue && (rbank == BIW'(b));

        single_port_RAM #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (FIFO_DEPTH / NUM_BANKS)
        ) u_ram (
            .clk   (clk),
            .en    (bank_wr || bank_rd),
            .we    (bank_wr),
            .addr  (bank_wr ? wrow : rrow),
            .wdata (in_data),
            .rdata (ram_q[b])
        );
    end

    reg_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (PREFETCH_DEPTH)
    ) u_prefetch (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .push      (rd_vld),
        .push_data (ram_q[rd_bank]),
        .pop       (out_fire),
        .pop_data  (out_data),
        .valid     (out_valid),
        .cnt       (pf_cnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            waddr   <= '0;
            raddr   <= '0;
            count   <= '0;
            rd_vld  <= 1'b0;
            rd_bank <= '0;
        end else if (clear) begin
            waddr   <= '0;
            raddr   <= '0;
            count   <= '0;
            rd_vld  <= 1'b0;
            rd_bank <= '0;
        end else begin
            if (wr_fire) begin
                waddr <= addr_next(waddr);
            end
            if (rd_issue) begin
                raddr   <= addr_next(raddr);
                rd_bank <= rbank;
            end
            rd_vld <= rd_issue;
            case ({wr_fire, out_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

`ifdef SYNC_NBANK_FIFO_ALMOST_FLAGS_EN
    assign almost_full  = (int'(count) >= FIFO_DEPTH - AF_MARGIN);
    assign almost_empty = (int'(count) <= AE_MARGIN);
`endif

endmodule

// File: tb/tb_sync_nbank_fifo.sv
module tb_sync_nbank_fifo;

    logic       clk = 1'b0;
    logic       rstn;
    logic       clear;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
`ifdef SYNC_NBANK_FIFO_ALMOST_FLAGS_EN
    logic       almost_full;
    logic       almost_empty;
`endif

    sync_nbank_fifo #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (16),
        .NUM_BANKS  (2),
        .AF_MARGIN  (2),
        .AE_MARGIN  (1)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clear     (clear),
        .count     (count)
`ifdef SYNC_NBANK_FIFO_ALMOST_FLAGS_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;

    // Advance one cycle; inputs are set at the falling edge, handshakes are
    // sampled just after and recorded into the scoreboard queues.
    task automatic tick();
        #1;
        if (clear) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                n_acc++;
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL release_count: got %0d expected 0", count); end
        @(negedge clk);
        // mid-stream reset
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h40 + i);
            tick();
        end
        in_valid = 1'b0;
        rstn = 1'b0;
        exp_q.delete();
        got_q.delete();
        #1;
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL midrst_count: got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_release_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic [7:0] e;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_t1_out_valid: got %b expected 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_t2_out_valid: got %b expected 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lat_t3_out_valid: got %b expected 1", out_valid); end
        n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL lat_t3_out_data: got %h expected a5", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        while (got_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL lat_sb: got %h expected nothing", got_q.pop_front());
            end else begin
                e = exp_q.pop_front();
                if (got_q[0] !== e) begin n_err++; $display("FAIL lat_sb: got %h expected %h", got_q[0], e); end
                void'(got_q.pop_front());
            end
        end
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL lat_count: got %0d expected 0", count); end
    endtask

    task automatic test_full();
        int budget;
        logic [7:0] e;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        budget    = 0;
        while (exp_q.size() < 16 && budget < 200) begin
            in_data = 8'(exp_q.size());
            tick();
            budget++;
        end
        n_cmp++; if (exp_q.size() != 16) begin n_err++; $display("FAIL full_fill_timeout: got %0d words expected 16", exp_q.size()); end
        in_valid = 1'b0;
        repeat (6) tick();
        n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL full_count: got %0d expected 16", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        in_valid = 1'b1;
        in_data  = 8'hEE;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (got_q.size() < 16 && budget < 200) begin
            tick();
            budget++;
        end
        out_ready = 1'b0;
        n_cmp++; if (got_q.size() != 16) begin n_err++; $display("FAIL full_drain_count: got %0d words expected 16", got_q.size()); end
        for (int i = 0; got_q.size() > 0; i++) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL full_sb[%0d]: got %h expected nothing", i, got_q.pop_front());
            end else begin
                e = exp_q.pop_front();
                if (got_q[0] !== e || got_q[0] !== 8'(i)) begin n_err++; $display("FAIL full_sb[%0d]: got %h expected %h", i, got_q[0], 8'(i)); end
                void'(got_q.pop_front());
            end
        end
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL full_drained_count: got %0d expected 0", count); end
    endtask

    task automatic test_conflict_stream();
        int budget;
        int reads_before;
        int n_seen;
        logic [7:0] e;
        n_acc     = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        budget    = 0;
        while (n_acc < 2 && budget < 50) begin
            in_data = 8'(8'h10 + n_acc);
            tick();
            budget++;
        end
        reads_before = got_q.size();
        out_ready = 1'b1;
        repeat (64) begin
            in_data = 8'(8'h10 + n_acc);
            tick();
        end
        n_cmp++;
        if (got_q.size() - reads_before < 32) begin
            n_err++; $display("FAIL stream_reads: got %0d reads expected at least 32", got_q.size() - reads_before);
        end
        in_valid = 1'b0;
        budget = 0;
        while ((count != 5'd0 || out_valid) && budget < 200) begin
            tick();
            budget++;
        end
        out_ready = 1'b0;
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL stream_deadlock: count got %0d expected 0", count); end
        n_seen = 0;
        while (got_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL stream_sb[%0d]: got %h expected nothing", n_seen, got_q.pop_front());
            end else begin
                e = exp_q.pop_front();
                if (got_q[0] !== e) begin n_err++; $display("FAIL stream_sb[%0d]: got %h expected %h", n_seen, got_q[0], e); end
                void'(got_q.pop_front());
            end
            n_seen++;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stream_leftover: got %0d unread expected 0", exp_q.size()); end
    endtask

    task automatic test_clear();
        int budget;
        logic [7:0] e;
        n_acc     = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        budget    = 0;
        while (n_acc < 10 && budget < 100) begin
            in_data = 8'(8'h50 + n_acc);
            tick();
            budget++;
        end
        in_valid = 1'b0;
        repeat (3) tick();
        n_cmp++; if (count !== 5'd10) begin n_err++; $display("FAIL clear_pre_count: got %0d expected 10", count); end
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL clear_count: got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clear_out_valid: got %b expected 0", out_valid); end
        n_acc    = 0;
        in_valid = 1'b1;
        budget   = 0;
        while (n_acc < 2 && budget < 50) begin
            in_data = 8'(8'h33 + n_acc);
            tick();
            budget++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (got_q.size() < 2 && budget < 50) begin
            tick();
            budget++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (got_q.size() == 0) begin
            n_err++; $display("FAIL clear_first_word: got nothing expected 33");
        end else if (got_q[0] !== 8'h33) begin
            n_err++; $display("FAIL clear_first_word: got %h expected 33", got_q[0]);
        end
        while (got_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL clear_sb: got %h expected nothing", got_q.pop_front());
            end else begin
                e = exp_q.pop_front();
                if (got_q[0] !== e) begin n_err++; $display("FAIL clear_sb: got %h expected %h", got_q[0], e); end
                void'(got_q.pop_front());
            end
        end
    endtask

`ifdef SYNC_NBANK_FIFO_ALMOST_FLAGS_EN
    task automatic test_almost();
        int budget;
        logic [7:0] e;
        n_cmp++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin n_err++; $display("FAIL almost_at0: got ae=%b af=%b expected ae=1 af=0", almost_empty, almost_full); end
        n_acc     = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        budget    = 0;
        while (n_acc < 1 && budget < 20) begin
            in_data = 8'(8'hC0 + n_acc);
            tick();
            budget++;
        end
        in_valid = 1'b0;
        n_cmp++; if (count !== 5'd1 || almost_empty !== 1'b1) begin n_err++; $display("FAIL almost_empty_at1: got count=%0d ae=%b expected count=1 ae=1", count, almost_empty); end
        in_valid = 1'b1;
        budget   = 0;
        while (n_acc < 13 && budget < 100) begin
            in_data = 8'(8'hC0 + n_acc);
            tick();
            budget++;
        end
        in_valid = 1'b0;
        n_cmp++; if (count !== 5'd13 || almost_full !== 1'b0 || almost_empty !== 1'b0) begin n_err++; $display("FAIL almost_at13: got count=%0d af=%b ae=%b expected 13 0 0", count, almost_full, almost_empty); end
        in_valid = 1'b1;
        budget   = 0;
        while (n_acc < 14 && budget < 20) begin
            in_data = 8'(8'hC0 + n_acc);
            tick();
            budget++;
        end
        in_valid = 1'b0;
        n_cmp++; if (count !== 5'd14 || almost_full !== 1'b1) begin n_err++; $display("FAIL almost_full_at14: got count=%0d af=%b expected 14 1", count, almost_full); end
        out_ready = 1'b1;
        budget    = 0;
        while (count != 5'd0 && budget < 100) begin
            tick();
            budget++;
        end
        out_ready = 1'b0;
        while (got_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL almost_sb: got %h expected nothing", got_q.pop_front());
            end else begin
                e = exp_q.pop_front();
                if (got_q[0] !== e) begin n_err++; $display("FAIL almost_sb: got %h expected %h", got_q[0], e); end
                void'(got_q.pop_front());
            end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn      = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        #1;
        rstn = 1'b0;
        test_reset();
        test_latency();
        test_full();
        test_conflict_stream();
        test_clear();
`ifdef SYNC_NBANK_FIFO_ALMOST_FLAGS_EN
        test_almost();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_nbank_fifo.md
SYNC_NBANK_FIFO -- requirements
Module: sync_nbank_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: in/out data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 256: total capacity in words; a multiple of NUM_BANKS.
REQ-003 SHALL have parameter NUM_BANKS, default 2: number of interleaved single-port RAM banks; a power of two, at least 2.
REQ-004 SHALL have parameters AF_MARGIN and AE_MARGIN, default 4 each: almost-flag thresholds, used only under REQ-027.
REQ-005 SHALL have port clk, input, 1 bit: the single clock. All logic is on the rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port in_data, input, DATA_WIDTH bits: write data.
REQ-008 SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: the write handshake.
REQ-009 SHALL have port out_data, output, DATA_WIDTH bits: read data.
REQ-010 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: the read handshake.
REQ-011 SHALL have port clear, input, 1 bit: synchronous flush.
REQ-012 SHALL have port count, output, $clog2(FIFO_DEPTH)+1 bits: words held.

Function
REQ-013 SHALL store word n in bank (n mod NUM_BANKS) at bank address (n / NUM_BANKS); waddr and raddr wrap modulo FIFO_DEPTH.
REQ-014 SHALL transfer a word when valid and ready are both high in the same cycle; in_ready SHALL NOT depend on in_valid, and out_valid SHALL NOT depend on out_ready.
REQ-015 SHALL drive in_ready = (count < FIFO_DEPTH) and not read_priority_conflict; in_ready SHALL be 0 when full.
REQ-016 SHALL issue a prefetch read from the bank of raddr when all of the following hold: the memory holds unread words; prefetch occupancy plus in-flight reads is below PREFETCH_DEPTH (4); and the bank is not being written that cycle.
REQ-017 SHALL resolve a same-bank conflict between a write and a pending prefetch as follows:
- the write wins, unless prefetch occupancy plus in-flight reads is at most 1;
- in that case the read wins and in_ready is 0 for that cycle (read_priority_conflict).
REQ-018 SHALL allow a write and a prefetch read to different banks in the same cycle.
REQ-019 SHALL deliver read data 2 cycles after issue (RAM read, then staging register) into the prefetch FIFO.
REQ-020 SHALL have a latency of 3 cycles: a word written at cycle T into an empty, idle FIFO gives out_valid=1 at T+3.
REQ-021 SHALL count every word held (RAM, in-flight and prefetch): +1 on a write only, -1 on a read only, unchanged on both or neither.
REQ-022 SHALL preserve strict FIFO order across all banks and conflict cases.
REQ-023 SHALL, on clear high while rstn is high, discard any concurrent write. In the next cycle count, pointers and in-flight valids SHALL be 0 and out_valid SHALL be 0.

Reset
REQ-024 SHALL, while rstn is low, asynchronously zero count, waddr, raddr, the in-flight valids and the prefetch FIFO, and force in_ready=0 and out_valid=0.
REQ-025 SHALL have in_ready=1 and count=0 in the first cycle after rstn deasserts.
REQ-026 SHALL NOT reset RAM contents; out_data is don't-care while out_valid=0.

Configuration
REQ-027 SHALL, with SYNC_NBANK_FIFO_ALMOST_FLAGS_EN defined, add outputs almost_full = (count >= FIFO_DEPTH-AF_MARGIN) and almost_empty = (count <= AE_MARGIN), both decoded from the count register.
REQ-028 SHALL, without SYNC_NBANK_FIFO_ALMOST_FLAGS_EN, omit these ports and their logic.

Structure
REQ-029 SHALL place PREFETCH_DEPTH (4), RAM_RD_LATENCY (2) and the bank-index/bank-address width helper functions in package sync_nbank_fifo_pkg.
REQ-030 SHALL instantiate the codebase single_port_RAM once per bank (depth FIFO_DEPTH/NUM_BANKS) and reg_fifo as the prefetch buffer. No new sub-module is needed.

Verification (DATA_WIDTH=8, FIFO_DEPTH=16, NUM_BANKS=2)
REQ-031 SHALL verify reset: rstn low mid-stream -> count=0, out_valid=0, in_ready=0 at once; after release in_ready=1.
REQ-032 SHALL verify full: write 0x00..0x0F with out_ready=0 -> count=16, in_ready=0; then drain -> 0x00..0x0F in order, count=0.
REQ-033 SHALL verify latency: write 0xA5 at cycle T into an empty FIFO -> out_valid=1 and out_data=0xA5 at T+3.
REQ-034 SHALL verify the bank-conflict stream: preload 2 words, then in_valid=out_ready=1 for 64 cycles -> order preserved, at least 32 reads, no deadlock.
REQ-035 SHALL verify clear: clear pulse with count=10 plus a concurrent write -> next cycle count=0, out_valid=0; a later write 0x33 is the first word read.
REQ-036 SHALL verify the almost flags with the macro defined, AF_MARGIN=2 and AE_MARGIN=1: count=14 -> almost_full=1; count=1 -> almost_empty=1.
